// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry for the direct-mapped L1 data cache
package dcache_pkg;
    localparam int ADDR_W     = 32;
    localparam int NUM_LINES  = 32;
    localparam int LINE_BITS  = 256;
    localparam int WORD_W     = 32;
    localparam int TAG_W      = 22;
    localparam int IDX_W      = 5;
    localparam int OFF_W      = 5;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_t;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [IDX_W-1:0]     idx_t;

    function automatic logic [ADDR_W-1:0] line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/data/valid/dirty storage, one write port and one async read port
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  idx_t                  rd_idx,
    output tag_t                  rd_tag,
    output line_t                 rd_line,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    input  logic                  wr_en,
    input  logic                  wr_full,
    input  idx_t                  wr_idx,
    input  tag_t                  wr_tag,
    input  line_t                 wr_line,
    input  logic [WORD_SEL_W-1:0] wr_word_sel,
    input  logic [WORD_W-1:0]     wr_word
);
    tag_t                 tag_mem  [NUM_LINES];
    line_t                data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];

    // A full-line write is a refill (clean); a word write is a CPU store (dirty).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            if (wr_full) begin
                valid[wr_idx] <= 1'b1;
                dirty[wr_idx] <= 1'b0;
            end else begin
                dirty[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays keep their contents across reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            if (wr_full) begin
                tag_mem[wr_idx]  <= wr_tag;
                data_mem[wr_idx] <= wr_line;
            end else begin
                data_mem[wr_idx][{wr_word_sel, 5'b0} +: WORD_W] <= wr_word;
            end
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-back, write-allocate direct-mapped L1 data cache controller
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [WORD_W-1:0]    p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [WORD_W-1:0]    p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);
    state_t state;
    tag_t   req_tag;
    idx_t   req_idx;

    tag_t                  p1_tag;
    idx_t                  p1_idx;
    logic [WORD_SEL_W-1:0] p1_word;
    logic                  unused_addr_bits;

    assign p1_tag           = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1_idx           = p1_addr_i[OFF_W +: IDX_W];
    assign p1_word          = p1_addr_i[2 +: WORD_SEL_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    logic is_write, is_read, req;
    assign is_write = p1_MemWrite_i;
    assign is_read  = p1_MemRead_i & ~p1_MemWrite_i;
    assign req      = p1_MemRead_i | p1_MemWrite_i;

    tag_t  rd_tag;
    line_t rd_line;
    logic  rd_valid, rd_dirty;
    idx_t  sram_idx;
    logic  wr_en, wr_full, hit;

    // Outside IDLE the array is addressed by the registered miss index, not the live CPU address.
    assign sram_idx = (state == IDLE) ? p1_idx : req_idx;
    assign hit      = rd_valid & (rd_tag == p1_tag);
    assign wr_full  = (state == REFILL);
    assign wr_en    = ((state == IDLE) & is_write & hit) | ((state == REFILL) & mem_ack_i);

    dcache_sram u_sram (
        .clk         (clk_i),
        .resetn      (rst_i),
        .rd_idx      (sram_idx),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .wr_en       (wr_en),
        .wr_full     (wr_full),
        .wr_idx      (sram_idx),
        .wr_tag      (req_tag),
        .wr_line     (mem_data_i),
        .wr_word_sel (p1_word),
        .wr_word     (p1_data_i)
    );

    assign p1_stall_o = (state != IDLE) | (req & ~hit);
    assign p1_data_o  = ((state == IDLE) && is_read && hit) ? rd_line[{p1_word, 5'b0} +: WORD_W] : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            req_tag      <= '0;
            req_idx      <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        req_tag      <= p1_tag;
                        req_idx      <= p1_idx;
                        mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= line_addr(rd_tag, p1_idx);
                            mem_data_o  <= rd_line;
                        end else begin
                            state       <= REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= line_addr(p1_tag, p1_idx);
                        end
                    end
                end
                WRITEBACK: begin
                    // The refill that follows is a separate transaction; enable stays high.
                    if (mem_ack_i) begin
                        state       <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= line_addr(req_tag, req_idx);
                        mem_data_o  <= '0;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state        <= IDLE;
                        mem_enable_o <= 1'b0;
                        mem_addr_o   <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule
